// File: rtl/ddr3_wr_packer.sv
// ddr3_wr_packer: packs 16-bit pixels into 128-bit MIG write words and
// buffers them in a single-clock show-ahead FIFO for the DDR3 controller.
// Optional build macro: WR_PACKER_LINE_FLUSH_EN -- when defined, a pixel
// flagged with pix_eol flushes the partial word into the FIFO, padded with
// zero pixels and with the unfilled bytes masked off.
module ddr3_wr_packer #(
    parameter int PIX_W        = 16,
    parameter int PIX_PER_WORD = 8,
    parameter int FIFO_DEPTH   = 1024,
    parameter int CNT_W        = 11,
    localparam int DATA_W      = PIX_W * PIX_PER_WORD,
    localparam int MASK_W      = DATA_W / 8
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic              wr_load,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_eol,
    input  logic              app_wdf_wren,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_wdf_mask,
    output logic [CNT_W-1:0]  wfifo_rcount,
    output logic              wfifo_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int IDX_W         = $clog2(PIX_PER_WORD);
    localparam int ADDR_W        = CNT_W - 1;
    localparam int BYTES_PER_PIX = PIX_W / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic              wr_load_q;
    logic              fs;
    logic [IDX_W-1:0]  pack_idx;
    logic [IDX_W-1:0]  eff_idx;
    logic [DATA_W-1:0] pack_data;
    logic [DATA_W-1:0] eff_data;
    logic [DATA_W-1:0] cur_word;
    logic [MASK_W-1:0] cur_mask;
    logic              word_done;
    logic              push_valid;
    logic [DATA_W-1:0] push_word;
    logic [MASK_W-1:0] push_mask;
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [MASK_W-1:0] mask_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic              do_pop;
    logic              do_push;
    logic              push_blocked;

    assign fs = wr_load & ~wr_load_q;

    // Register wr_load so its rising edge can be detected as frame start
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) wr_load_q <= 1'b0;
        else                 wr_load_q <= wr_load;
    end

    // Merge the incoming pixel into the word; a frame start restarts from an empty word
    always_comb begin
        eff_idx   = fs ? '0 : pack_idx;
        eff_data  = fs ? '0 : pack_data;
        cur_word  = eff_data | (DATA_W'(pix_data) << (PIX_W * int'(eff_idx)));
        word_done = (eff_idx == LAST_IDX);
        cur_mask  = '0;
`ifdef WR_PACKER_LINE_FLUSH_EN
        word_done = word_done | pix_eol;
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            if (k > int'(eff_idx)) cur_mask[k*BYTES_PER_PIX +: BYTES_PER_PIX] = '1;
        end
`endif
    end

`ifndef WR_PACKER_LINE_FLUSH_EN
    logic unused_pix_eol;
    assign unused_pix_eol = pix_eol;
`endif

    // Accumulate pixels; a finished word waits one cycle in the push stage before entering the FIFO
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            pack_idx   <= '0;
            pack_data  <= '0;
            push_valid <= 1'b0;
            push_word  <= '0;
            push_mask  <= '0;
        end else begin
            push_valid <= 1'b0;
            if (pix_valid) begin
                if (word_done) begin
                    push_valid <= 1'b1;
                    push_word  <= cur_word;
                    push_mask  <= cur_mask;
                    pack_idx   <= '0;
                    pack_data  <= '0;
                end else begin
                    pack_idx   <= eff_idx + 1'b1;
                    pack_data  <= cur_word;
                end
            end else if (fs) begin
                pack_idx  <= '0;
                pack_data <= '0;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO is only dropped without one
    always_comb begin
        do_pop       = app_wdf_wren & (wfifo_rcount != '0);
        push_blocked = (wfifo_rcount == FULL_CNT) & ~do_pop;
        do_push      = push_valid & ~push_blocked & ~fs & ~ui_clk_sync_rst;
        count_next   = wfifo_rcount;
        case ({do_push, do_pop})
            2'b10:   count_next = wfifo_rcount + 1'b1;
            2'b01:   count_next = wfifo_rcount - 1'b1;
            default: count_next = wfifo_rcount;
        endcase
    end

    // Word storage is not reset; the count alone decides what is valid
    always_ff @(posedge ui_clk) begin
        if (do_push) begin
            data_mem[wr_ptr] <= push_word;
            mask_mem[wr_ptr] <= push_mask;
        end
    end

    // FIFO pointers, occupancy and sticky error flags; frame start empties everything
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst || fs) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wfifo_rcount <= '0;
            wfifo_full   <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            wfifo_rcount <= count_next;
            wfifo_full   <= (count_next == FULL_CNT);
            if (push_valid && push_blocked)           overflow  <= 1'b1;
            if (app_wdf_wren && wfifo_rcount == '0)   underflow <= 1'b1;
        end
    end

    assign app_wdf_data = (wfifo_rcount != '0) ? data_mem[rd_ptr] : '0;
    assign app_wdf_mask = (wfifo_rcount != '0) ? mask_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ddr3_wr_packer.sv
// tb_ddr3_wr_packer: randomized and directed bench for ddr3_wr_packer,
// compared every cycle against a queue-based model of the packer and FIFO.
module tb_ddr3_wr_packer;

    localparam int DEPTH = 1024;

    logic          ui_clk = 1'b0;
    logic          ui_clk_sync_rst;
    logic          wr_load;
    logic          pix_valid;
    logic [15:0]   pix_data;
    logic          pix_eol;
    logic          app_wdf_wren;
    logic [127:0]  app_wdf_data;
    logic [15:0]   app_wdf_mask;
    logic [10:0]   wfifo_rcount;
    logic          wfifo_full;
    logic          overflow;
    logic          underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [127:0] exp_q[$];
    logic [15:0]  exp_mq[$];
    logic [15:0]  part[$];
    logic [15:0]  stream_q[$];
    bit           pend_v;
    logic [127:0] pend_w;
    logic [15:0]  pend_m;
    bit           m_ovf;
    bit           m_unf;
    bit           m_load_q;

    ddr3_wr_packer dut (
        .ui_clk          (ui_clk),
        .ui_clk_sync_rst (ui_clk_sync_rst),
        .wr_load         (wr_load),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_eol         (pix_eol),
        .app_wdf_wren    (app_wdf_wren),
        .app_wdf_data    (app_wdf_data),
        .app_wdf_mask    (app_wdf_mask),
        .wfifo_rcount    (wfifo_rcount),
        .wfifo_full      (wfifo_full),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    // 100 MHz user clock
    always #5 ui_clk = ~ui_clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Builds a word from n pixels: pixel 0 in the LSBs, absent pixels zero
    function automatic logic [127:0] buildWord(input logic [15:0] px[$]);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < px.size(); k++) w[16*k +: 16] = px[k];
        return w;
    endfunction

    task automatic modelReset();
        exp_q.delete(); exp_mq.delete(); part.delete();
        pend_v = 0; m_ovf = 0; m_unf = 0; m_load_q = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs applied before the edge
    task automatic modelStep();
        bit fs;
        bit flush;
        fs = wr_load && !m_load_q;
        m_load_q = wr_load;
        if (fs) begin
            exp_q.delete(); exp_mq.delete(); part.delete();
            pend_v = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (app_wdf_wren) begin
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_mq.pop_front());
                end else begin
                    m_unf = 1;
                end
            end
            if (pend_v) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(pend_w);
                    exp_mq.push_back(pend_m);
                end else begin
                    m_ovf = 1;
                end
            end
            pend_v = 0;
        end
        if (pix_valid) begin
            part.push_back(pix_data);
            flush = (part.size() == 8);
`ifdef WR_PACKER_LINE_FLUSH_EN
            flush = flush || pix_eol;
`endif
            if (flush) begin
                pend_v = 1;
                pend_w = buildWord(part);
                pend_m = 16'hFFFF << (2 * part.size());
                part.delete();
            end
        end
    endtask

    task automatic checkAll(input string pfx);
        int n;
        n = exp_q.size();
        checkOutput({pfx, "_rcount"},    128'(wfifo_rcount), 128'(n));
        checkOutput({pfx, "_full"},      128'(wfifo_full), 128'(n == DEPTH));
        checkOutput({pfx, "_overflow"},  128'(overflow), 128'(m_ovf));
        checkOutput({pfx, "_underflow"}, 128'(underflow), 128'(m_unf));
        checkOutput({pfx, "_data"},      app_wdf_data, (n > 0) ? exp_q[0] : 128'h0);
        checkOutput({pfx, "_mask"},      128'(app_wdf_mask), (n > 0) ? 128'(exp_mq[0]) : 128'h0);
    endtask

    task automatic applyStimulus(input string pfx, input bit ld, input bit v, input logic [15:0] d,
                                 input bit eol, input bit wren);
        wr_load      = ld;
        pix_valid    = v;
        pix_data     = d;
        pix_eol      = eol;
        app_wdf_wren = wren;
        @(posedge ui_clk);
        modelStep();
        #1;
        checkAll(pfx);
    endtask

    task automatic applyReset();
        ui_clk_sync_rst = 1'b1;
        wr_load = 0; pix_valid = 0; pix_data = '0; pix_eol = 0; app_wdf_wren = 0;
        repeat (2) @(posedge ui_clk);
        modelReset();
        #1;
        ui_clk_sync_rst = 1'b0;
        checkAll("reset");
    endtask

    initial begin
        int maxcnt;
        logic [15:0] px[$];

        // Reset and the basic 16-pixel packing sequence
        applyReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus("seq16", 0, 1, 16'(i), 0, 0);
            if (i == 7) checkOutput("seq16_cnt_at_p7", 128'(wfifo_rcount), 128'd0);
            if (i == 8) begin
                checkOutput("seq16_cnt_after_p7", 128'(wfifo_rcount), 128'd1);
                checkOutput("seq16_word0", app_wdf_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
                checkOutput("seq16_mask0", 128'(app_wdf_mask), 128'h0);
            end
            if (i == 15) checkOutput("seq16_cnt_at_p15", 128'(wfifo_rcount), 128'd1);
        end
        applyStimulus("seq16", 0, 0, 16'h0, 0, 0);
        checkOutput("seq16_cnt_after_p15", 128'(wfifo_rcount), 128'd2);

        // Fill to capacity, then one extra word is dropped
        applyReset();
        for (int w = 0; w < DEPTH + 1; w++)
            for (int k = 0; k < 8; k++)
                applyStimulus("fill", 0, 1, 16'($urandom), 0, 0);
        applyStimulus("fill", 0, 0, 16'h0, 0, 0);
        checkOutput("fill_cnt", 128'(wfifo_rcount), 128'd1024);
        checkOutput("fill_full", 128'(wfifo_full), 128'd1);
        checkOutput("fill_ovf", 128'(overflow), 128'd1);
        // A push coinciding with a pop at full is accepted
        for (int k = 0; k < 8; k++) applyStimulus("fullpp", 0, 1, 16'($urandom), 0, 0);
        applyStimulus("fullpp", 0, 0, 16'h0, 0, 1);
        checkOutput("fullpp_cnt", 128'(wfifo_rcount), 128'd1024);
        checkOutput("fullpp_ovf", 128'(overflow), 128'd1);

        // Frame start empties the FIFO, then a pop on empty is flagged
        applyStimulus("fs_clear", 1, 0, 16'h0, 0, 0);
        checkOutput("fs_clear_cnt", 128'(wfifo_rcount), 128'd0);
        applyStimulus("underflow", 1, 0, 16'h0, 0, 1);
        checkOutput("underflow_flag", 128'(underflow), 128'd1);
        checkOutput("underflow_cnt", 128'(wfifo_rcount), 128'd0);
        checkOutput("underflow_data", app_wdf_data, 128'h0);

        // Partial word discarded by frame start; the fs-cycle pixel becomes pixel 0
        for (int k = 0; k < 5; k++) applyStimulus("fsmid", 0, 1, 16'(16'h0100 + k), 0, 0);
        applyStimulus("fsmid", 1, 1, 16'hABCD, 0, 0);
        for (int k = 0; k < 7; k++) applyStimulus("fsmid", 1, 1, 16'(16'h0200 + k), 0, 0);
        applyStimulus("fsmid", 1, 0, 16'h0, 0, 0);
        checkOutput("fsmid_cnt", 128'(wfifo_rcount), 128'd1);
        checkOutput("fsmid_word", app_wdf_data, 128'h0206_0205_0204_0203_0202_0201_0200_ABCD);
        checkOutput("fsmid_ovf", 128'(overflow), 128'd0);
        checkOutput("fsmid_unf", 128'(underflow), 128'd0);

        // Sustained streaming with one pop every eight cycles
        applyReset();
        stream_q.delete();
        maxcnt = 0;
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] d;
            bit pop;
            d = 16'($urandom);
            pop = (i % 8 == 3) && (exp_q.size() > 0);
            if (pop) begin
                px.delete();
                for (int k = 0; k < 8; k++) px.push_back(stream_q.pop_front());
                checkOutput("sustain_order", app_wdf_data, buildWord(px));
            end
            stream_q.push_back(d);
            applyStimulus("sustain", 0, 1, d, 0, pop);
            if (int'(wfifo_rcount) > maxcnt) maxcnt = int'(wfifo_rcount);
        end
        checkOutput("sustain_max_le2", 128'(maxcnt <= 2), 128'd1);

        // Randomized mix of frame starts, pixels, end-of-line markers and pops
        applyReset();
        for (int i = 0; i < 4000; i++)
            applyStimulus("random", ($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
                          16'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3));

        // Three pixels with end-of-line on the third
        applyReset();
        applyStimulus("eol", 0, 1, 16'h0001, 0, 0);
        applyStimulus("eol", 0, 1, 16'h0002, 0, 0);
        applyStimulus("eol", 0, 1, 16'h0003, 1, 0);
        applyStimulus("eol", 0, 0, 16'h0000, 0, 0);
`ifdef WR_PACKER_LINE_FLUSH_EN
        checkOutput("eol_cnt", 128'(wfifo_rcount), 128'd1);
        checkOutput("eol_mask", 128'(app_wdf_mask), 128'hFFC0);
        checkOutput("eol_word", app_wdf_data, 128'h0000_0000_0000_0000_0000_0003_0002_0001);
`else
        checkOutput("eol_cnt", 128'(wfifo_rcount), 128'd0);
        checkOutput("eol_mask", 128'(app_wdf_mask), 128'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
